// File: rtl/imem_boot_loader.sv
// imem_boot_loader
// Boot-time loader between a byte-stream host link and the core's instruction
// memory. It receives a length-prefixed image (count low byte, count high
// byte, then 4*count bytes, each word LSB first) and writes each assembled
// word to consecutive word addresses. It holds the core in reset until the
// image is complete, then releases it. A reload request from the running
// system restarts loading.
//
// Handshake: a byte moves when rx_valid && rx_ready are both high at a rising
// clk edge. rx_ready depends only on state (high in HDR0, HDR1 and DATA) and
// never on rx_valid. The host may hold rx_valid and rx_data until the byte is
// accepted. Dropping rx_valid between bytes only stalls the load; no byte is
// lost.
module imem_boot_loader #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  core_rst,
  input  logic                  reload,
  output logic                  done,
  output logic                  err,
  output logic [2:0]            dbg_state
);

  // Word capacity, in the same 17-bit range as word_idx. A count equal to
  // DEPTH is legal and fills the memory exactly.
  localparam logic [16:0] DEPTH = 17'(1) << ADDR_WIDTH;

  typedef enum logic [2:0] {
    S_HDR0    = 3'd0,
    S_HDR1    = 3'd1,
    S_DATA    = 3'd2,
    S_RELEASE = 3'd3,
    S_RUN     = 3'd4,
    S_ERR     = 3'd5
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [15:0] count;
  logic [16:0] word_idx;
  logic [1:0]  byte_idx;
  logic [23:0] asm_q;
  logic        xfer;
  logic [15:0] hdr_count;
  logic [16:0] last_idx;

  // Full count as it will be once the high byte is latched in HDR1.
  assign hdr_count = {rx_data, count[7:0]};

  // Index of the final word. It is only used in DATA, where count >= 1.
  assign last_idx = {1'b0, count} - 17'd1;

  assign xfer      = rx_valid & rx_ready;
  assign dbg_state = state;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_HDR0;
    else      state <= state_next;
  end

  // Next-state logic plus outputs decoded from state.
  always_comb begin
    state_next = state;
    rx_ready   = 1'b0;
    core_rst   = 1'b1;
    done       = 1'b0;
    err        = 1'b0;
    case (state)
      S_HDR0: begin
        rx_ready = 1'b1;
        if (rx_valid) state_next = S_HDR1;
      end
      S_HDR1: begin
        rx_ready = 1'b1;
        if (rx_valid) begin
          if (hdr_count == 16'd0)             state_next = S_RELEASE;
          else if ({1'b0, hdr_count} > DEPTH) state_next = S_ERR;
          else                                state_next = S_DATA;
        end
      end
      S_DATA: begin
        rx_ready = 1'b1;
        if (rx_valid && byte_idx == 2'd3 && word_idx == last_idx)
          state_next = S_RELEASE;
      end
      S_RELEASE: state_next = S_RUN;
      S_RUN: begin
        core_rst = 1'b0;
        done     = 1'b1;
        // rx_ready is low here, so a byte that arrives together with reload
        // stays with the host and becomes the next count low byte.
        if (reload) state_next = S_HDR0;
      end
      S_ERR: err = 1'b1;
      default: state_next = S_HDR0;
    endcase
  end

  // Datapath: header latch, byte assembly and the one-cycle write strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count      <= 16'd0;
      word_idx   <= 17'd0;
      byte_idx   <= 2'd0;
      asm_q      <= 24'd0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= 32'd0;
    end else begin
      imem_we <= 1'b0;
      if (xfer) begin
        case (state)
          S_HDR0: count[7:0] <= rx_data;
          S_HDR1: begin
            count[15:8] <= rx_data;
            word_idx    <= 17'd0;
            byte_idx    <= 2'd0;
          end
          S_DATA: begin
            byte_idx <= byte_idx + 2'd1;
            case (byte_idx)
              2'd0: asm_q[7:0]   <= rx_data;
              2'd1: asm_q[15:8]  <= rx_data;
              2'd2: asm_q[23:16] <= rx_data;
              default: begin
                // The fourth byte completes the word. Address and data stay
                // on the outputs after the strobe drops.
                imem_we    <= 1'b1;
                imem_wdata <= {rx_data, asm_q};
                imem_addr  <= word_idx[ADDR_WIDTH-1:0];
                word_idx   <= word_idx + 17'd1;
              end
            endcase
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Testbench for imem_boot_loader: byte driver tasks, a write scoreboard and a
// bench-side instruction memory that is filled from the write strobe.
module tb_imem_boot_loader;

  localparam int AW = 8;
  localparam logic [2:0] S_HDR0    = 3'd0;
  localparam logic [2:0] S_RELEASE = 3'd3;
  localparam logic [2:0] S_ERR     = 3'd5;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [7:0]    rx_data = 8'd0;
  logic          rx_valid = 1'b0;
  logic          rx_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          core_rst;
  logic          reload = 1'b0;
  logic          done;
  logic          err;
  logic [2:0]    dbg_state;

  int total = 0;
  int bad   = 0;

  logic [AW+31:0] exp_q[$];
  logic [AW+31:0] mon_exp;
  logic [31:0]    img[$];
  logic [31:0]    mem[0:255];

  imem_boot_loader #(.ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_rst   (core_rst),
    .reload     (reload),
    .done       (done),
    .err        (err),
    .dbg_state  (dbg_state)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // Write scoreboard. Every strobe must match the next expected {addr, data}.
  always @(negedge clk) begin
    if (rst && imem_we) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write: addr=%0h data=%08h, required no write",
                 imem_addr, imem_wdata);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({imem_addr, imem_wdata} !== mon_exp) begin
          bad++;
          $display("FAIL write: addr=%0h data=%08h, required addr=%0h data=%08h",
                   imem_addr, imem_wdata, mon_exp[AW+31:32], mon_exp[31:0]);
        end
      end
      mem[imem_addr] = imem_wdata;
    end
  end

  // ---------------- driver tasks (entered and left on a falling edge) -----
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      total++;
      bad++;
      $display("FAIL send_timeout: rx_ready=%b, required 1", rx_ready);
    end
    @(negedge clk);
  endtask

  task automatic idle();
    rx_valid = 1'b0;
    @(negedge clk);
  endtask

  // Sends img as an image. The expected write is queued before the edge that
  // accepts each word's fourth byte.
  task automatic send_image(input bit gap);
    int cnt;
    logic [31:0] w32;
    cnt = img.size();
    send_byte(cnt[7:0]);
    if (gap) idle();
    send_byte(cnt[15:8]);
    for (int w = 0; w < cnt; w++) begin
      w32 = img[w];
      for (int k = 0; k < 4; k++) begin
        if (gap) idle();
        if (k == 3) exp_q.push_back({AW'(w), w32});
        send_byte(w32[8*k +: 8]);
      end
    end
    rx_valid = 1'b0;
  endtask

  task automatic do_reload();
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic wait_done(input int bound);
    int n;
    n = 0;
    while (!done && n < bound) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (done !== 1'b1) begin
      bad++;
      $display("FAIL wait_done_timeout: done=%b, required 1", done);
    end
  endtask

  // ---------------- scenarios --------------------------------------------
  task automatic test_reset();
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total++;
    if ({rx_ready, imem_we, imem_addr, imem_wdata, core_rst, done, err, dbg_state}
        !== {1'b1, 1'b0, AW'(0), 32'd0, 1'b1, 1'b0, 1'b0, S_HDR0}) begin
      bad++;
      $display("FAIL reset_values: rdy=%b we=%b addr=%0h wd=%08h crst=%b done=%b err=%b st=%0d, required 1 0 0 0 1 0 0 0",
               rx_ready, imem_we, imem_addr, imem_wdata, core_rst, done, err, dbg_state);
    end
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (rx_ready !== 1'b1 || core_rst !== 1'b1 || dbg_state !== S_HDR0) begin
      bad++;
      $display("FAIL reset_idle: rdy=%b crst=%b st=%0d, required 1 1 0", rx_ready, core_rst, dbg_state);
    end
  endtask

  task automatic test_two_words();
    img = '{32'h00A00513, 32'h00100593};
    send_image(1'b0);
    total++;
    if (imem_we !== 1'b1 || core_rst !== 1'b1) begin
      bad++;
      $display("FAIL two_words_last_strobe: we=%b crst=%b, required 1 1", imem_we, core_rst);
    end
    @(negedge clk);
    total++;
    if (core_rst !== 1'b0 || done !== 1'b1 || imem_we !== 1'b0) begin
      bad++;
      $display("FAIL two_words_release: crst=%b done=%b we=%b, required 0 1 0", core_rst, done, imem_we);
    end
    total++;
    if (imem_addr !== AW'(1) || imem_wdata !== 32'h00100593) begin
      bad++;
      $display("FAIL two_words_hold: addr=%0h wd=%08h, required 1 00100593", imem_addr, imem_wdata);
    end
    total++;
    if (mem[0] !== 32'h00A00513 || mem[1] !== 32'h00100593) begin
      bad++;
      $display("FAIL two_words_mem: m0=%08h m1=%08h, required 00a00513 00100593", mem[0], mem[1]);
    end
  endtask

  task automatic test_reload_zero();
    // Byte and reload together in RUN: reload wins, the byte waits.
    rx_data  = 8'h55;
    rx_valid = 1'b1;
    reload   = 1'b1;
    total++;
    if (rx_ready !== 1'b0) begin
      bad++;
      $display("FAIL run_rx_ready: rx_ready=%b, required 0", rx_ready);
    end
    @(negedge clk);
    reload   = 1'b0;
    rx_valid = 1'b0;
    total++;
    if (core_rst !== 1'b1 || done !== 1'b0 || rx_ready !== 1'b1 || dbg_state !== S_HDR0) begin
      bad++;
      $display("FAIL reload_state: crst=%b done=%b rdy=%b st=%0d, required 1 0 1 0",
               core_rst, done, rx_ready, dbg_state);
    end
    send_byte(8'h00);
    send_byte(8'h00);
    rx_valid = 1'b0;
    total++;
    if (dbg_state !== S_RELEASE || core_rst !== 1'b1) begin
      bad++;
      $display("FAIL zero_release: st=%0d crst=%b, required 3 1", dbg_state, core_rst);
    end
    @(negedge clk);
    total++;
    if (core_rst !== 1'b0 || done !== 1'b1) begin
      bad++;
      $display("FAIL zero_run: crst=%b done=%b, required 0 1", core_rst, done);
    end
  endtask

  task automatic test_toggle();
    do_reload();
    img = '{32'hCAFEF00D};
    send_image(1'b1);
    @(negedge clk);
    total++;
    if (done !== 1'b1 || mem[0] !== 32'hCAFEF00D) begin
      bad++;
      $display("FAIL toggle_load: done=%b m0=%08h, required 1 cafef00d", done, mem[0]);
    end
  endtask

  task automatic test_rst_mid();
    logic [31:0] saved1;
    do_reload();
    send_byte(8'h02);
    send_byte(8'h00);
    exp_q.push_back({AW'(0), 32'h11223344});
    send_byte(8'h44);
    send_byte(8'h33);
    send_byte(8'h22);
    send_byte(8'h11);
    send_byte(8'h88);
    rx_valid = 1'b0;
    saved1 = mem[1];
    #2 rst = 1'b0;
    #1;
    total++;
    if ({rx_ready, imem_we, imem_addr, imem_wdata, core_rst, done, dbg_state}
        !== {1'b1, 1'b0, AW'(0), 32'd0, 1'b1, 1'b0, S_HDR0}) begin
      bad++;
      $display("FAIL async_reset: rdy=%b we=%b addr=%0h wd=%08h crst=%b done=%b st=%0d, required 1 0 0 0 1 0 0",
               rx_ready, imem_we, imem_addr, imem_wdata, core_rst, done, dbg_state);
    end
    @(negedge clk);
    rst = 1'b1;
    img = '{32'hDEADBEEF};
    send_image(1'b0);
    @(negedge clk);
    total++;
    if (mem[0] !== 32'hDEADBEEF || mem[1] !== saved1 || done !== 1'b1) begin
      bad++;
      $display("FAIL rst_reload: m0=%08h m1=%08h done=%b, required deadbeef %08h 1",
               mem[0], mem[1], done, saved1);
    end
  endtask

  task automatic test_full();
    do_reload();
    img.delete();
    for (int i = 0; i < 256; i++) img.push_back($urandom_range(32'hFFFF_FFFF, 0));
    send_image(1'b0);
    @(negedge clk);
    total++;
    if (done !== 1'b1 || imem_addr !== AW'(8'hFF) || mem[255] !== img[255] || mem[0] !== img[0]) begin
      bad++;
      $display("FAIL full_depth: done=%b addr=%0h m255=%08h m0=%08h, required 1 ff %08h %08h",
               done, imem_addr, mem[255], mem[0], img[255], img[0]);
    end
  endtask

  task automatic test_err();
    do_reload();
    send_byte(8'h01);
    send_byte(8'h01);
    rx_valid = 1'b0;
    total++;
    if (err !== 1'b1 || rx_ready !== 1'b0 || core_rst !== 1'b1 || done !== 1'b0) begin
      bad++;
      $display("FAIL err_enter: err=%b rdy=%b crst=%b done=%b, required 1 0 1 0", err, rx_ready, core_rst, done);
    end
    rx_valid = 1'b1;
    rx_data  = 8'hA5;
    reload   = 1'b1;
    repeat (5) @(negedge clk);
    rx_valid = 1'b0;
    reload   = 1'b0;
    total++;
    if (err !== 1'b1 || dbg_state !== S_ERR || core_rst !== 1'b1) begin
      bad++;
      $display("FAIL err_sticky: err=%b st=%0d crst=%b, required 1 5 1", err, dbg_state, core_rst);
    end
    do_reset();
    total++;
    if (err !== 1'b0 || rx_ready !== 1'b1 || dbg_state !== S_HDR0) begin
      bad++;
      $display("FAIL err_clear: err=%b rdy=%b st=%0d, required 0 1 0", err, rx_ready, dbg_state);
    end
    img = '{32'h0BADC0DE};
    send_image(1'b0);
    wait_done(10);
  endtask

  // ---------------- sequence and report ---------------------------------
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    @(negedge clk);
    test_reset();
    test_two_words();
    test_reload_zero();
    test_toggle();
    test_rst_mid();
    test_full();
    test_err();
    repeat (3) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL pending_writes: %0d outstanding, required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
